// File: rtl/msrv32_instruction_encoder_pkg.sv
// Shared types and constants for the instruction encoder block.
// Format codes, FSM states, NOP word and RV32I opcodes.
package msrv32_instruction_encoder_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/msrv32_instr_word_encoder.sv
// Combinational packing of instruction fields into an RV32I word.
// Illegal formats produce the canonical NOP and flag illegal_o.
module msrv32_instr_word_encoder
    import msrv32_instruction_encoder_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [2:0]            fmt_i,
    input  logic [6:0]            opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic [ADDR_WIDTH-1:0] rs1_i,
    input  logic [ADDR_WIDTH-1:0] rs2_i,
    input  logic [ADDR_WIDTH-1:0] rd_i,
    input  logic [WIDTH-1:0]      imm_i,
    output logic [31:0]           word_o,
    output logic                  illegal_o
);

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;

    assign rs1 = 5'(rs1_i);
    assign rs2 = 5'(rs2_i);
    assign rd  = 5'(rd_i);
    assign imm = 32'(imm_i);

    always_comb begin
        word_o    = NOP_WORD;
        illegal_o = 1'b0;
        unique case (1'b1)
            (fmt_i == FMT_R):
                word_o = {funct7_i, rs2, rs1, funct3_i, rd, opcode_i};
            (fmt_i == FMT_I):
                word_o = {imm[11:0], rs1, funct3_i, rd, opcode_i};
            (fmt_i == FMT_S):
                word_o = {imm[11:5], rs2, rs1, funct3_i, imm[4:0], opcode_i};
            (fmt_i == FMT_B):
                word_o = {imm[12], imm[10:5], rs2, rs1, funct3_i,
                          imm[4:1], imm[11], opcode_i};
            (fmt_i == FMT_U):
                word_o = {imm[31:12], rd, opcode_i};
            (fmt_i == FMT_J):
                word_o = {imm[20], imm[10:1], imm[11], imm[19:12],
                          rd, opcode_i};
            default: begin
                word_o    = NOP_WORD;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/msrv32_instruction_encoder.sv
// Field-handshake instruction encoder feeding a small word FIFO that
// drains into the instruction-memory write port under an IDLE/RUN/DRAIN FSM.
module msrv32_instruction_encoder
    import msrv32_instruction_encoder_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  ms_riscv32_mp_clk_in,
    input  logic                  ms_riscv32_mp_rst_n_in,
    input  logic                  start_in,
    input  logic                  stop_in,
    input  logic [WIDTH-1:0]      base_addr_in,
    input  logic                  fld_valid_in,
    output logic                  fld_ready_out,
    input  logic [2:0]            fmt_in,
    input  logic [6:0]            opcode_in,
    input  logic [2:0]            funct3_in,
    input  logic [6:0]            funct7_in,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_in,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    input  logic [WIDTH-1:0]      imm_in,
    input  logic                  flush_in,
    output logic [WIDTH-1:0]      ms_riscv32_mp_imaddr_out,
    output logic [WIDTH-1:0]      ms_riscv32_mp_imdata_out,
    output logic                  ms_riscv32_mp_imwr_req_out,
    input  logic                  ms_riscv32_mp_imwr_hready_in,
    output logic [15:0]           instr_count_out,
    output logic                  busy_out,
    output logic                  err_illegal_fmt_out
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_e            state_q, state_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [31:0]       mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              req_q, req_d;
    logic [15:0]       count_q, count_d;
    logic              err_q, err_d;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        fifo_full;
    logic        fifo_empty;
    logic        start_go;
    logic        push;
    logic        pop;
    logic        wr_done;

    msrv32_instr_word_encoder #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_enc (
        .fmt_i      (fmt_in),
        .opcode_i   (opcode_in),
        .funct3_i   (funct3_in),
        .funct7_i   (funct7_in),
        .rs1_i      (rs1_addr_in),
        .rs2_i      (rs2_addr_in),
        .rd_i       (rd_addr_in),
        .imm_i      (imm_in),
        .word_o     (enc_word),
        .illegal_o  (enc_illegal)
    );

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign fld_ready_out = (state_q == ST_RUN) && !fifo_full;

    assign start_go = (state_q == ST_IDLE) && start_in;
    assign wr_done  = req_q && ms_riscv32_mp_imwr_hready_in;
    assign push     = fld_valid_in && fld_ready_out && !flush_in;
    // A completing write frees the port, so the next word can follow at once.
    assign pop      = !fifo_empty && !flush_in && (!req_q || wr_done);

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        req_d   = req_q;
        count_d = count_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE:  if (start_in) state_d = ST_RUN;
            ST_RUN:   if (stop_in) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty && !req_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (start_go) begin
            addr_d  = base_addr_in;
            count_d = '0;
            err_d   = 1'b0;
        end else if (wr_done) begin
            addr_d = addr_q + WIDTH'(4);
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end

        if (push && enc_illegal) err_d = 1'b1;

        if (wr_done) req_d = 1'b0;
        if (pop) begin
            data_d = WIDTH'(mem_q[rptr_q]);
            req_d  = 1'b1;
            rptr_d = ptr_inc(rptr_q);
        end

        if (flush_in) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = enc_word;
                wptr_d = ptr_inc(wptr_q);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            req_q   <= req_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign ms_riscv32_mp_imaddr_out   = addr_q;
    assign ms_riscv32_mp_imdata_out   = data_q;
    assign ms_riscv32_mp_imwr_req_out = req_q;
    assign instr_count_out            = count_q;
    assign err_illegal_fmt_out        = err_q;
    assign busy_out = (state_q != ST_IDLE) || req_q;

endmodule

// File: tb/tb_msrv32_instruction_encoder.sv
// Directed-vector bench for msrv32_instruction_encoder.
// Expected words and addresses are hand-computed RV32I encodings.
module tb_msrv32_instruction_encoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [31:0] base;
    logic        vld;
    logic        rdy;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        flush;
    logic [31:0] addr;
    logic [31:0] data;
    logic        req;
    logic        hready;
    logic [15:0] cnt;
    logic        busy;
    logic        err;

    int n_vec;
    int n_bad;

    msrv32_instruction_encoder dut (
        .ms_riscv32_mp_clk_in         (clk),
        .ms_riscv32_mp_rst_n_in       (rst_n),
        .start_in                     (start),
        .stop_in                      (stop),
        .base_addr_in                 (base),
        .fld_valid_in                 (vld),
        .fld_ready_out                (rdy),
        .fmt_in                       (fmt),
        .opcode_in                    (op),
        .funct3_in                    (f3),
        .funct7_in                    (f7),
        .rs1_addr_in                  (rs1),
        .rs2_addr_in                  (rs2),
        .rd_addr_in                   (rd),
        .imm_in                       (imm),
        .flush_in                     (flush),
        .ms_riscv32_mp_imaddr_out     (addr),
        .ms_riscv32_mp_imdata_out     (data),
        .ms_riscv32_mp_imwr_req_out   (req),
        .ms_riscv32_mp_imwr_hready_in (hready),
        .instr_count_out              (cnt),
        .busy_out                     (busy),
        .err_illegal_fmt_out          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fld(input logic [2:0] f, input logic [6:0] o,
                           input logic [2:0] fn3, input logic [6:0] fn7,
                           input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d, input logic [31:0] im);
        fmt = f; op = o; f3 = fn3; f7 = fn7;
        rs1 = s1; rs2 = s2; rd = d; imm = im;
    endtask

    task automatic accept_addi(input logic [31:0] im);
        set_fld(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, im);
        vld = 1'b1;
        tick();
        vld = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] b);
        base = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 0; stop = 0; base = '0; vld = 0; flush = 0;
        hready = 1'b1;
        set_fld(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);

        #12;
        check("rst_req",   32'(req),  32'd0);
        check("rst_addr",  addr,      32'd0);
        check("rst_data",  data,      32'd0);
        check("rst_cnt",   32'(cnt),  32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_rdy",   32'(rdy),  32'd0);
        check("rst_err",   32'(err),  32'd0);
        rst_n = 1'b1;
        tick();

        // R-type: add x3,x1,x2
        do_start(32'h100);
        check("run_rdy",   32'(rdy),  32'd1);
        check("run_busy",  32'(busy), 32'd1);
        check("run_addr",  addr,      32'h100);
        set_fld(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        check("r_lat0_req", 32'(req), 32'd0);
        tick();
        check("r_req",     32'(req),  32'd1);
        check("r_data",    data,      32'h002081B3);
        check("r_addr",    addr,      32'h100);
        tick();
        check("r_done",    32'(req),  32'd0);
        check("r_cnt",     32'(cnt),  32'd1);
        check("r_addr4",   addr,      32'h104);

        // Empty FIFO: stop returns to IDLE
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("drain_busy", 32'(busy), 32'd1);
        tick();
        check("idle_busy",  32'(busy), 32'd0);

        // I then B, back-to-back
        do_start(32'h100);
        check("restart_cnt", 32'(cnt), 32'd0);
        set_fld(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        vld = 1'b1;
        tick();
        set_fld(3'd3, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
        tick();
        vld = 1'b0;
        check("i_req",   32'(req), 32'd1);
        check("i_data",  data,     32'h00500093);
        check("i_addr",  addr,     32'h100);
        tick();
        check("b_req",   32'(req), 32'd1);
        check("b_data",  data,     32'h00208463);
        check("b_addr",  addr,     32'h104);
        check("b_cnt1",  32'(cnt), 32'd1);
        tick();
        check("b_done",  32'(req), 32'd0);
        check("b_cnt2",  32'(cnt), 32'd2);

        // J-type with stalled write port
        hready = 1'b0;
        set_fld(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h800);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) hready = 1'b1;
            check("j_req",  32'(req), 32'd1);
            check("j_data", data,     32'h001000EF);
            check("j_addr", addr,     32'h108);
            check("j_cnt",  32'(cnt), 32'd2);
            tick();
        end
        check("j_done",  32'(req), 32'd0);
        check("j_cnt3",  32'(cnt), 32'd3);
        check("j_addr4", addr,     32'h10C);

        // Illegal format -> NOP, sticky error
        set_fld(3'd6, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        check("ill_err",  32'(err), 32'd1);
        tick();
        check("ill_data", data,     32'h00000013);
        check("ill_addr", addr,     32'h10C);
        tick();
        check("ill_cnt",  32'(cnt), 32'd4);
        check("ill_err2", 32'(err), 32'd1);

        // Fill FIFO behind a stalled write, then flush
        hready = 1'b0;
        accept_addi(32'd1);
        accept_addi(32'd2);
        accept_addi(32'd3);
        check("full_rdy",  32'(rdy), 32'd0);
        check("full_data", data,     32'h00100093);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_rdy",  32'(rdy), 32'd1);
        check("fl_req",  32'(req), 32'd1);
        check("fl_data", data,     32'h00100093);
        hready = 1'b1;
        tick();
        check("fl_done", 32'(req), 32'd0);
        check("fl_cnt",  32'(cnt), 32'd5);
        tick();
        tick();
        check("fl_noreq", 32'(req), 32'd0);
        check("fl_cnt2",  32'(cnt), 32'd5);

        // Stop with a non-empty FIFO
        hready = 1'b0;
        accept_addi(32'd4);
        accept_addi(32'd6);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("dr_busy", 32'(busy), 32'd1);
        check("dr_rdy",  32'(rdy),  32'd0);
        hready = 1'b1;
        tick();
        check("dr_data", data, 32'h00600093);
        check("dr_addr", addr, 32'h118);
        begin
            int k;
            k = 0;
            while (busy && k < 10) begin
                tick();
                k++;
            end
        end
        check("dr_idle", 32'(busy), 32'd0);
        check("dr_cnt",  32'(cnt),  32'd7);
        check("dr_addr2", addr,     32'h11C);
        check("dr_err",  32'(err),  32'd1);

        do_start(32'h200);
        check("st_err",  32'(err), 32'd0);
        check("st_cnt",  32'(cnt), 32'd0);
        check("st_addr", addr,     32'h200);

        // Asynchronous reset during a stalled write
        hready = 1'b0;
        accept_addi(32'd7);
        tick();
        check("mw_req", 32'(req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req",  32'(req),  32'd0);
        check("ar_addr", addr,      32'd0);
        check("ar_data", data,      32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_rdy",  32'(rdy),  32'd0);
        check("ar_cnt",  32'(cnt),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/msrv32_instruction_encoder.md
MSRV32_INSTRUCTION_ENCODER -- requirements
Module: msrv32_instruction_encoder

Interface
REQ-001 SHALL have parameters: WIDTH, default 32, data/address width; ADDR_WIDTH, default 5, register-address width; FIFO_DEPTH, default 2, encoded-word buffer depth.
REQ-002 SHALL have ports: ms_riscv32_mp_clk_in  input  1  sole clock, rising edge.
REQ-003 ms_riscv32_mp_rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 start_in  input  1  one-cycle pulse that starts a load session; stop_in  input  1  one-cycle pulse that ends the session after drain.
REQ-005 base_addr_in  input  WIDTH  first write address, sampled on start.
REQ-006 fld_valid_in  input  1 / fld_ready_out  output  1  field handshake.
REQ-007 fmt_in  input  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J; 6 and 7 illegal.
REQ-008 opcode_in 7, funct3_in 3, funct7_in 7, rs1_addr_in/rs2_addr_in/rd_addr_in ADDR_WIDTH, imm_in WIDTH; all inputs.
REQ-009 flush_in  input  1  discards buffered words.
REQ-010 ms_riscv32_mp_imaddr_out  output  WIDTH; ms_riscv32_mp_imdata_out  output  WIDTH; ms_riscv32_mp_imwr_req_out  output  1; ms_riscv32_mp_imwr_hready_in  input  1.
REQ-011 instr_count_out  output  16  words written; busy_out  output  1; err_illegal_fmt_out  output  1  sticky.

Function
REQ-012 SHALL implement FSM IDLE, RUN, DRAIN; start_in in IDLE -> RUN; stop_in in RUN -> DRAIN; DRAIN with FIFO empty and no pending write -> IDLE.
REQ-013 start_in outside IDLE SHALL be ignored; stop_in outside RUN SHALL be ignored.
REQ-014 On start: imaddr <= base_addr_in, instr_count <= 0, err_illegal_fmt <= 0.
REQ-015 fld_ready_out SHALL be 1 only in RUN with FIFO not full, derived from registered state only.
REQ-016 A field is accepted on a clock edge where fld_valid_in and fld_ready_out are both 1; the encoded word enters the FIFO on that edge.
REQ-017 Encoding, opcode always bits 6:0:
- R: funct7|rs2|rs1|f3|rd
- I: imm[11:0]|rs1|f3|rd
- S: imm[11:5]|rs2|rs1|f3|imm[4:0]
- B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]
- U: imm[31:12]|rd
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd
REQ-018 Illegal fmt SHALL encode 32'h00000013 (NOP) and set err_illegal_fmt_out until next start or reset.
REQ-019 Write port: when FIFO non-empty and no write pending, pop head onto imdata and assert imwr_req the next cycle; minimum latency from acceptance to imwr_req is 1 cycle.
REQ-020 imaddr, imdata and imwr_req SHALL hold stable while imwr_req=1 and imwr_hready_in=0.
REQ-021 Edge with imwr_req=1 and imwr_hready_in=1 completes a write: imaddr += 4 (wraps modulo 2^WIDTH), instr_count += 1 (saturates at 16'hFFFF); the next word may be presented the following cycle, giving back-to-back writes with no gap.
REQ-022 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-023 flush_in SHALL empty the FIFO in that cycle; a pending write (imwr_req=1) SHALL still complete; flush has priority over simultaneous push.
REQ-024 busy_out = (state != IDLE) or write pending.

Reset
REQ-025 Asserting ms_riscv32_mp_rst_n_in low SHALL immediately force: state IDLE, FIFO empty, imwr_req_out 0, imaddr_out 0, imdata_out 0, instr_count_out 0, err_illegal_fmt_out 0, fld_ready_out 0, busy_out 0, including mid-write.

Structure
REQ-026 A shared package SHALL hold format codes, FSM state encodings, the NOP constant 32'h00000013 and RV32I opcode constants.
REQ-027 Field-to-word encoding SHALL be one combinational sub-module, msrv32_instr_word_encoder; FIFO and FSM reside in the top.

Verification
REQ-028 R, rd=3, rs1=1, rs2=2, f3=0, f7=0, op=0x33, base=0x100, hready=1 -> write 0x002081B3 at 0x100 one cycle after acceptance, count=1.
REQ-029 I addi x1,x0,5 then B beq x1,x2,imm=8 -> writes 0x00500093 @0x100 and 0x00208463 @0x104 back-to-back.
REQ-030 J jal x1,imm=0x800 with hready=0 for 3 cycles -> 0x001000EF held stable 4 cycles; address and count advance only on the hready edge.
REQ-031 fmt=6 -> 0x00000013 written, err_illegal_fmt_out=1 until next start.
REQ-032 FIFO full with write stalled, then flush_in -> pending write completes, buffered words are never written, fld_ready_out returns to 1.
REQ-033 Reset asserted mid-write with imwr_req=1 -> all outputs 0 immediately; stop_in with FIFO non-empty -> DRAIN until empty, then IDLE, busy_out=0.
